// File: rtl/matrix_writer_pkg.sv
// Shared types and constants for the matrix result writer.
// Holds the FSM encoding, the status word layout and the default completion marker.
package matrix_writer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_DRAIN,
    ST_FLUSH,
    ST_STATUS,
    ST_DONE
  } state_t;

  localparam int STAT_MARKER_LSB = 0;
  localparam int STAT_COUNT_LSB  = 32;
  localparam int STAT_WORDS_LSB  = 64;
  localparam int STAT_OVF_BIT    = 96;

  localparam logic [31:0] DEFAULT_DONE_MARKER = 32'hFFFF_FFFF;

endpackage

// File: rtl/matrix_result_writer_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the pointer.
// The pointer moves to granted index + 1 only when the grant is actually taken.
module rr_arbiter #(
  parameter int N = 5
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] hi_idx;
  logic [PW-1:0] lo_idx;
  logic [PW-1:0] sel;
  logic          found_hi;

  always_comb begin
    hi_idx   = '0;
    lo_idx   = '0;
    found_hi = 1'b0;
    // Reverse scans so the lowest matching index is the one that sticks.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i] && (i >= int'(ptr))) begin
        found_hi = 1'b1;
        hi_idx   = PW'(i);
      end
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) lo_idx = PW'(i);
    end
    sel   = found_hi ? hi_idx : lo_idx;
    grant = (|req) ? (N'(1) << sel) : '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr <= '0;
    end else if (advance && (|req)) begin
      ptr <= (sel == PW'(N - 1)) ? '0 : sel + 1'b1;
    end
  end

endmodule

// File: rtl/matrix_result_writer.sv
// Collects elements from several producer lanes, packs them into RAM words and
// writes them out, then flushes a partial word and writes a completion status word.
module matrix_result_writer
  import matrix_writer_pkg::*;
#(
  parameter int          NUM_LANES   = 5,
  parameter int          DATA_W      = 32,
  parameter int          MEM_W       = 128,
  parameter int          ADDR_W      = 10,
  parameter int          BASE_ADDR   = 1,
  parameter int          STATUS_ADDR = 0,
  parameter logic [31:0] DONE_MARKER = DEFAULT_DONE_MARKER
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        finish,
  input  logic [NUM_LANES-1:0]        in_valid,
  input  logic [NUM_LANES*DATA_W-1:0] in_data,
  output logic [NUM_LANES-1:0]        in_ready,
  input  logic                        waitrequest,
  output logic [MEM_W-1:0]            write_data,
  output logic [MEM_W/8-1:0]          byteenable,
  output logic [ADDR_W-1:0]           address,
  output logic                        write,
  output logic                        clken,
  output logic                        chipselect,
  output logic                        busy,
  output logic                        done,
  output logic                        overflow,
  output state_t                      fsm_state
);

  localparam int SLOTS = MEM_W / DATA_W;
  localparam int BE_W  = MEM_W / 8;
  localparam int DB    = DATA_W / 8;
  localparam int FW    = $clog2(SLOTS + 1);
  localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] STATUS_A = ADDR_W'(STATUS_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  state_t state, state_nxt;

  logic [NUM_LANES-1:0] hold_valid;
  logic [DATA_W-1:0]    hold_data [NUM_LANES];
  logic [NUM_LANES-1:0] grant;
  logic [DATA_W-1:0]    gnt_data;
  logic                 grant_en, gnt_any;

  logic [MEM_W-1:0] pack_data;
  logic [FW-1:0]    fill;
  logic             pack_full;

  logic        stat_out;
  logic [31:0] elem_count, words_written, words_next;
  logic        out_free, accept, accept_data, ovf_next;
  logic        move, drain_ok, start_ok, flush_load, status_load;
  logic [BE_W-1:0]  flush_be;
  logic [MEM_W-1:0] status_word;

  // Lane handshake: an element transfers on a cycle where in_valid & in_ready are
  // both high at the rising edge; in_ready means the lane holder is empty and collecting.
  assign in_ready   = ~hold_valid & {NUM_LANES{state == ST_COLLECT}};
  assign clken      = 1'b1;
  assign chipselect = 1'b1;
  assign busy       = (state != ST_IDLE);
  assign done       = (state == ST_DONE);
  assign fsm_state  = state;

  assign pack_full   = (fill == FW'(SLOTS));
  assign out_free    = !write || !waitrequest;
  assign accept      = write && !waitrequest;
  assign accept_data = accept && !stat_out;
  assign ovf_next    = overflow || (accept_data && (address == ADDR_MAX));
  assign words_next  = words_written + (accept_data ? 32'd1 : 32'd0);
  assign grant_en    = ((state == ST_COLLECT) || (state == ST_DRAIN)) && !pack_full;
  assign gnt_any     = grant_en && (|hold_valid);
  assign move        = pack_full && out_free;
  assign drain_ok    = !(|hold_valid) && !pack_full && out_free;
  assign start_ok    = (state == ST_IDLE) && start;
  assign flush_load  = (state == ST_FLUSH) && (fill != '0) && !ovf_next;
  assign status_load = (state == ST_STATUS) && !stat_out && out_free;

  rr_arbiter #(.N(NUM_LANES)) u_arb (
    .clock   (clock),
    .reset   (reset),
    .req     (hold_valid),
    .advance (gnt_any),
    .grant   (grant)
  );

  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (grant[i]) gnt_data = gnt_data | hold_data[i];
    end
  end

  always_comb begin
    flush_be = '0;
    for (int k = 0; k < SLOTS; k++) begin
      if (k < int'(fill)) flush_be[k*DB +: DB] = '1;
    end
  end

  // Status reflects any data write retiring on the same edge the status is loaded.
  always_comb begin
    status_word = '0;
    status_word[STAT_MARKER_LSB +: 32] = DONE_MARKER;
    status_word[STAT_COUNT_LSB  +: 32] = elem_count;
    status_word[STAT_WORDS_LSB  +: 32] = words_next;
    status_word[STAT_OVF_BIT]          = ovf_next;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (start) state_nxt = ST_COLLECT;
      ST_COLLECT: if (finish) state_nxt = ST_DRAIN;
      ST_DRAIN:   if (drain_ok) state_nxt = ST_FLUSH;
      ST_FLUSH:   state_nxt = ST_STATUS;
      ST_STATUS:  if (stat_out && accept) state_nxt = ST_DONE;
      ST_DONE:    state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_LANES; i++) begin
      if (in_valid[i] && in_ready[i]) hold_data[i] <= in_data[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= ST_IDLE;
      hold_valid    <= '0;
      pack_data     <= '0;
      fill          <= '0;
      write         <= 1'b0;
      write_data    <= '0;
      byteenable    <= '0;
      address       <= BASE_A;
      stat_out      <= 1'b0;
      elem_count    <= '0;
      words_written <= '0;
      overflow      <= 1'b0;
    end else begin
      state <= state_nxt;

      for (int i = 0; i < NUM_LANES; i++) begin
        if (gnt_any && grant[i]) hold_valid[i] <= 1'b0;
        if (in_valid[i] && in_ready[i]) hold_valid[i] <= 1'b1;
      end

      if (start_ok) begin
        elem_count    <= '0;
        words_written <= '0;
        overflow      <= 1'b0;
      end else begin
        if (gnt_any) elem_count <= elem_count + 32'd1;
        words_written <= words_next;
        overflow      <= ovf_next;
      end

      if (move || (state == ST_FLUSH)) begin
        pack_data <= '0;
        fill      <= '0;
      end else if (gnt_any) begin
        pack_data[int'(fill)*DATA_W +: DATA_W] <= gnt_data;
        fill <= fill + 1'b1;
      end

      // Address register doubles as the next free data address between writes.
      if (accept) write <= 1'b0;
      if (accept_data) address <= address + 1'b1;
      if (move) begin
        write      <= !ovf_next;
        write_data <= pack_data;
        byteenable <= '1;
      end
      if (flush_load) begin
        write      <= 1'b1;
        write_data <= pack_data;
        byteenable <= flush_be;
      end
      if (status_load) begin
        write      <= 1'b1;
        write_data <= status_word;
        byteenable <= '1;
        address    <= STATUS_A;
        stat_out   <= 1'b1;
      end
      if (state == ST_DONE) begin
        address  <= BASE_A;
        stat_out <= 1'b0;
      end
    end
  end

endmodule

// File: doc/matrix_result_writer.md
# matrix_result_writer

Parametrised successor to the UKF output controller. Accepts result elements from NUM_LANES producer lanes (diagonal plus lower-triangle lanes of the decomposition core) and packs them into MEM_W-bit words. Writes them sequentially into the on-chip result RAM through its s2 slave port. On finish it flushes any partial word with correct byteenables, then writes a status/completion word at STATUS_ADDR.

## Interface
- NUM_LANES, 5, producer lanes; lane 0 = diagonal, 1..NUM_LANES-1 = lower lanes
- DATA_W, 32, element width
- MEM_W, 128, RAM word width; multiple of DATA_W and ≥128; SLOTS = MEM_W/DATA_W
- ADDR_W, 10, RAM address width
- BASE_ADDR, 1, first data word address
- STATUS_ADDR, 0, status word address
- DONE_MARKER, 32'hFFFFFFFF, status word bits [31:0]

Ports:
- clock  in  1  single clock; everything on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  pulse; arms block from IDLE
- finish  in  1  pulse; ends current matrix
- in_valid  in  NUM_LANES  per-lane element valid
- in_data  in  NUM_LANES*DATA_W  lane i at [i*DATA_W +: DATA_W]
- in_ready  out  NUM_LANES  lane holding register empty and block collecting
- waitrequest  in  1  RAM stall; write held while high
- write_data  out  MEM_W  RAM write data
- byteenable  out  MEM_W/8  RAM byte enables
- address  out  ADDR_W  RAM word address
- write  out  1  RAM write strobe
- clken, chipselect  out  1  tied 1
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse after status write accepted
- overflow  out  1  sticky; address space exhausted

## Operation
- States: IDLE → COLLECT (on start) → DRAIN (on finish) → FLUSH → STATUS → DONE → IDLE. start while not IDLE ignored. finish in IDLE ignored.
- Per-lane one-entry holding register. Capture on in_valid & in_ready. in_ready = holder empty & state==COLLECT.
- Round-robin arbiter grants one non-empty holder per cycle into the packer. After a grant, priority moves to granted index +1. Grant only when packer not full.
- Packer fills slots in order: slot k at bits [k*DATA_W +: DATA_W]. When slot SLOTS-1 fills, the packed word moves to the output register and the packer clears on the same edge. This move requires the output register to be free (write low, or write & !waitrequest).
- Accepted write = write & !waitrequest. After each accepted data write, address increments and words_written increments.
- Full words: byteenable all ones.
- DRAIN: wait for all holders empty and output register free.
- FLUSH: if packer holds n>0 slots, issue one write with byteenable set for the low n*DATA_W/8 bytes and unused slots zero. If n=0, skip the write.
- STATUS: write at STATUS_ADDR with byteenable all ones:
  - [31:0] DONE_MARKER
  - [63:32] element count
  - [95:64] words_written
  - [96] overflow
  - all remaining bits 0
- DONE: done=1 for one cycle. Address reloads BASE_ADDR. Counters clear on the next start.
- Overflow: a data write accepted at address 2^ADDR_W−1 sets overflow. Later data writes are suppressed (write stays low) but element count still increments. The status write is always issued.

## Timing
- Reset values: write=0, byteenable=0, write_data=0, address=BASE_ADDR, in_ready=0, done=0, busy=0, overflow=0, all holders empty, state IDLE.
- Latency: element captured at edge t is granted at edge t+1 at earliest. If it completes a word, write is high from t+2.
- Output register is always driven. write, address, write_data and byteenable are stable while waitrequest is high.
- Simultaneous word completion and pending write: the packer stalls (no grant) until the output register is free. Holders back-pressure via in_ready.
- finish in the same cycle as a capture: that element is accepted and included.
- Reset mid-operation: everything returns to reset values on the next edge. No write is issued.

## Structure
- Package matrix_writer_pkg: state enum, status field offsets, default DONE_MARKER.
- Sub-module rr_arbiter (parameter N; inputs req[N], advance; output grant one-hot) holds the rotating priority pointer.

## Test plan
- **Single lane fill:** start; lane 0 sends 8 elements 0x1..0x8 with waitrequest=0 → writes at addr 1 {4,3,2,1} and addr 2 {8,7,6,5}, byteenable FFFF.
- **All lanes contend:** all 5 lanes valid in one cycle → grants in order 0,1,2,3,4. Next round starts at lane 0. Word 1 = lanes 3,2,1,0.
- **Partial flush:** 6 elements then finish → addr 2 gets byteenable 00FF. Status at addr 0 = marker FFFFFFFF, count 6, words 2, overflow 0. done pulses once.
- **Backpressure:** waitrequest high 5 cycles during a write → outputs held constant and no data lost. in_ready drops once holders fill.
- **Overflow:** ADDR_W=3, 40 elements → last data write at addr 7, overflow=1, status count 40, words 7.
- **Reset mid-COLLECT:** reset asserted after 3 elements → next cycle address=1, write=0, state IDLE, no status write.
